// File: rtl/uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_ctrl
// Description : Receive-side controller for the UART receiver engine. Holds
//               the baud/frame configuration and drives it to the engine.
//               Drains each received byte and its error flags into a
//               first-word-fall-through FIFO, then pulses rx_clr to re-arm
//               the engine.
//               Optional feature macro: RX_TIMEOUT_EN (idle timeout on a
//               non-empty FIFO, folded into irq).
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_ctrl #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  // receiver engine
  input  logic          rx_rdy,
  input  logic [7:0]    rx_data,
  input  logic          rx_ferr,
  input  logic          rx_perr,
  input  logic          rx_ovf,
  output logic          rx_clr,
  output logic [18:0]   k,
  output logic          eight,
  output logic          pen,
  output logic          even,
  // host side
  input  logic          cfg_we,
  input  logic [7:0]    cfg_wdata,
  input  logic          rd,
  output logic [7:0]    rd_data,
  output logic [2:0]    rd_status,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count,
  output logic          ovr,
  output logic          irq,
  output logic          timeout
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [1:0]    c_st_idle    = 2'd0;
  localparam logic [1:0]    c_st_capture = 2'd1;
  localparam logic [1:0]    c_st_clear   = 2'd2;
  localparam logic [1:0]    c_st_wait    = 2'd3;

  localparam logic [18:0]   c_k_reset    = 19'd10417;
  localparam logic [AW:0]   c_full_cnt   = (AW+1)'(DEPTH);
  localparam logic [AW:0]   c_cnt_one    = (AW+1)'(1);
  localparam logic [AW-1:0] c_ptr_one    = AW'(1);

  // --------------------------------------------------------------------------
  // Baud select to divisor lookup; codes above 8 all map to the fastest rate
  // --------------------------------------------------------------------------
  function automatic logic [18:0] baud_k(input logic [3:0] sel);
    logic [18:0] v;
    case (sel)
      4'd0:    v = 19'd333333;
      4'd1:    v = 19'd83333;
      4'd2:    v = 19'd41667;
      4'd3:    v = 19'd20833;
      4'd4:    v = 19'd10417;
      4'd5:    v = 19'd5208;
      4'd6:    v = 19'd2604;
      4'd7:    v = 19'd1736;
      default: v = 19'd868;
    endcase
    return v;
  endfunction

  // --------------------------------------------------------------------------
  // Internal signals
  // --------------------------------------------------------------------------
  logic [1:0]    r_state;
  logic [10:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_ovr;

  logic          w_push_req;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic [10:0]   w_head;
  logic          w_unused_cfg;

  // Reserved configuration bit carries no function
  assign w_unused_cfg = cfg_wdata[0];

  // --------------------------------------------------------------------------
  // Configuration registers: loaded on cfg_we, reset to 9600-class defaults
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      k     <= c_k_reset;
      eight <= 1'b1;
      pen   <= 1'b0;
      even  <= 1'b0;
    end else if (cfg_we) begin
      k     <= baud_k(cfg_wdata[7:4]);
      eight <= cfg_wdata[3];
      pen   <= cfg_wdata[2];
      even  <= cfg_wdata[1];
    end
  end

  // --------------------------------------------------------------------------
  // Drain FSM: capture one frame, clear the engine, wait for RXRDY to drop.
  // A config write forces CLEAR so stale engine flags are discarded.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_st_idle;
    end else if (cfg_we) begin
      r_state <= c_st_clear;
    end else begin
      case (r_state)
        c_st_idle:    if (rx_rdy) r_state <= c_st_capture;
        c_st_capture: r_state <= c_st_clear;
        c_st_clear:   r_state <= c_st_wait;
        c_st_wait:    if (!rx_rdy) r_state <= c_st_idle;
        default:      r_state <= c_st_idle;
      endcase
    end
  end

  assign rx_clr = (r_state == c_st_clear);

  // --------------------------------------------------------------------------
  // FIFO control. A pop frees a slot before the push is judged, so a full
  // FIFO with a simultaneous pop still accepts the incoming byte. A config
  // write discards any push or pop in the same cycle.
  // --------------------------------------------------------------------------
  assign empty      = (r_count == '0);
  assign full       = (r_count == c_full_cnt);
  assign count      = r_count;
  assign w_push_req = (r_state == c_st_capture) && !cfg_we;
  assign w_pop      = rd && !empty && !cfg_we;
  assign w_push     = w_push_req && (!full || w_pop);
  assign w_drop     = w_push_req && full && !w_pop;

  // Storage array: entry layout is {ovf, ferr, perr, data}
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {rx_ovf, rx_ferr, rx_perr, rx_data};
    end
  end

  // Pointers and occupancy; pointers wrap naturally at DEPTH = 2**AW
  always_ff @(posedge clk) begin
    if (rst || cfg_we) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_one;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_cnt_one;
        2'b01:   r_count <= r_count - c_cnt_one;
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky overrun flag: set when a captured byte finds no room
  always_ff @(posedge clk) begin
    if (rst || cfg_we) begin
      r_ovr <= 1'b0;
    end else if (w_drop) begin
      r_ovr <= 1'b1;
    end
  end

  assign ovr = r_ovr;

  // Head-of-FIFO view, forced to zero while empty
  assign w_head    = empty ? 11'd0 : r_mem[r_rd_ptr];
  assign rd_data   = w_head[7:0];
  assign rd_status = w_head[10:8];

`ifdef RX_TIMEOUT_EN
  // --------------------------------------------------------------------------
  // Idle timeout: roughly three character times (32*k clocks) without a
  // push or pop while data sits in the FIFO.
  // --------------------------------------------------------------------------
  logic [23:0] r_idle_cnt;
  logic        r_timeout;
  logic [23:0] w_idle_limit;
  logic [23:0] w_idle_inc;

  assign w_idle_limit = {k, 5'b0};
  assign w_idle_inc   = r_idle_cnt + 24'd1;

  // Idle counter: restarts on any FIFO activity, config write or empty FIFO
  always_ff @(posedge clk) begin
    if (rst || cfg_we || w_push || w_pop || empty) begin
      r_idle_cnt <= '0;
    end else if (!r_timeout) begin
      r_idle_cnt <= w_idle_inc;
    end
  end

  // Timeout flag: set when the counter reaches the limit, held until a pop
  always_ff @(posedge clk) begin
    if (rst || cfg_we || w_pop) begin
      r_timeout <= 1'b0;
    end else if (!empty && !w_push && !r_timeout && (w_idle_inc == w_idle_limit)) begin
      r_timeout <= 1'b1;
    end
  end

  assign timeout = r_timeout;
  assign irq     = !empty || r_timeout;
`else
  assign timeout = 1'b0;
  assign irq     = !empty;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_ctrl
// Description : Self-checking bench for uart_rx_ctrl. Table of configuration
//               vectors, directed corner sequences and a randomized phase,
//               all checked against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_ctrl;

  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          rx_rdy;
  logic [7:0]    rx_data;
  logic          rx_ferr, rx_perr, rx_ovf;
  logic          rx_clr;
  logic [18:0]   k;
  logic          eight, pen, even;
  logic          cfg_we;
  logic [7:0]    cfg_wdata;
  logic          rd;
  logic [7:0]    rd_data;
  logic [2:0]    rd_status;
  logic          empty, full;
  logic [AW:0]   count;
  logic          ovr, irq, timeout;

  uart_rx_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .rx_rdy(rx_rdy), .rx_data(rx_data), .rx_ferr(rx_ferr), .rx_perr(rx_perr),
    .rx_ovf(rx_ovf), .rx_clr(rx_clr), .k(k), .eight(eight), .pen(pen), .even(even),
    .cfg_we(cfg_we), .cfg_wdata(cfg_wdata), .rd(rd), .rd_data(rd_data),
    .rd_status(rd_status), .empty(empty), .full(full), .count(count),
    .ovr(ovr), .irq(irq), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int clr_cnt = 0;

  // rx_clr high cycles, sampled mid-cycle
  always @(negedge clk) if (rx_clr === 1'b1) clr_cnt++;

  // Reference model state
  logic [10:0] mq[$];
  logic        m_ovr;
  logic [18:0] m_k;
  logic        m_eight, m_pen, m_even;

  typedef struct {
    logic [7:0]  wdata;
    logic [18:0] k;
    logic        eight;
    logic        pen;
    logic        even;
  } cfg_vec_t;

  cfg_vec_t tbl[12];

  function automatic logic [18:0] exp_k(input logic [3:0] sel);
    int ktab[9];
    ktab = '{333333, 83333, 41667, 20833, 10417, 5208, 2604, 1736, 868};
    return (sel > 4'd8) ? 19'd868 : 19'(ktab[sel]);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_model(input string tag);
    logic [10:0] h;
    int n;
    n = mq.size();
    h = (n > 0) ? mq[0] : 11'd0;
    chk({tag, " count"},     32'(count),     32'(n));
    chk({tag, " empty"},     32'(empty),     32'(n == 0));
    chk({tag, " full"},      32'(full),      32'(n == DEPTH));
    chk({tag, " ovr"},       32'(ovr),       32'(m_ovr));
    chk({tag, " rd_data"},   32'(rd_data),   32'(h[7:0]));
    chk({tag, " rd_status"}, 32'(rd_status), 32'(h[10:8]));
    chk({tag, " irq"},       32'(irq),       32'(n != 0));
    chk({tag, " timeout"},   32'(timeout),   32'd0);
  endtask

  task automatic check_cfg(input string tag);
    chk({tag, " k"},     32'(k),     32'(m_k));
    chk({tag, " eight"}, 32'(eight), 32'(m_eight));
    chk({tag, " pen"},   32'(pen),   32'(m_pen));
    chk({tag, " even"},  32'(even),  32'(m_even));
  endtask

  // Config write; leaves the FSM back in IDLE
  task automatic cfg_write(input logic [7:0] d, input logic [18:0] ek,
                           input logic e8, input logic ep, input logic ee);
    cfg_we = 1'b1;
    cfg_wdata = d;
    tick(1);
    cfg_we = 1'b0;
    cfg_wdata = 8'h00;
    m_k = ek; m_eight = e8; m_pen = ep; m_even = ee;
    mq.delete();
    m_ovr = 1'b0;
    chk("cfg rx_clr pulse", 32'(rx_clr), 32'd1);
    check_cfg("cfg");
    check_model("cfg flush");
    tick(1);
    chk("cfg rx_clr end", 32'(rx_clr), 32'd0);
    tick(1);
  endtask

  // One engine frame: hold RXRDY until rx_clr, plus 'hold' extra cycles
  task automatic send_byte(input logic [7:0] d, input logic [2:0] fl,
                           input int hold, output int lat);
    int c0;
    int n;
    c0 = clr_cnt;
    rx_data = d;
    {rx_ovf, rx_ferr, rx_perr} = fl;
    rx_rdy = 1'b1;
    n = 0;
    while (rx_clr !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    lat = n;
    chk("rx_clr seen", 32'(n < 10), 32'd1);
    @(posedge clk);
    #1;
    tick(hold);
    rx_rdy = 1'b0;
    tick(1);
    chk("rx_clr pulses per frame", 32'(clr_cnt - c0), 32'd1);
    if (mq.size() < DEPTH) mq.push_back({fl, d});
    else m_ovr = 1'b1;
  endtask

  task automatic pop_one(input string tag);
    check_model({tag, " pre"});
    rd = 1'b1;
    tick(1);
    rd = 1'b0;
    if (mq.size() > 0) void'(mq.pop_front());
    check_model({tag, " post"});
  endtask

  // Pop asserted exactly on the edge where the captured byte is pushed
  task automatic push_pop(input string tag, input logic [7:0] d, input logic [2:0] fl);
    rx_data = d;
    {rx_ovf, rx_ferr, rx_perr} = fl;
    rx_rdy = 1'b1;
    tick(1);
    check_model({tag, " pre"});
    rd = 1'b1;
    tick(1);
    rd = 1'b0;
    if (mq.size() > 0) void'(mq.pop_front());
    if (mq.size() < DEPTH) mq.push_back({fl, d});
    else m_ovr = 1'b1;
    chk({tag, " rx_clr"}, 32'(rx_clr), 32'd1);
    check_model({tag, " post"});
    tick(1);
    rx_rdy = 1'b0;
    tick(1);
  endtask

  initial begin
    int lat;
    int c0;
    logic [7:0] rb;

    tbl[0]  = '{8'h00, 19'd333333, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{8'h1F, 19'd83333,  1'b1, 1'b1, 1'b1};
    tbl[2]  = '{8'h2A, 19'd41667,  1'b1, 1'b0, 1'b1};
    tbl[3]  = '{8'h36, 19'd20833,  1'b0, 1'b1, 1'b1};
    tbl[4]  = '{8'h48, 19'd10417,  1'b1, 1'b0, 1'b0};
    tbl[5]  = '{8'h5C, 19'd5208,   1'b1, 1'b1, 1'b0};
    tbl[6]  = '{8'h64, 19'd2604,   1'b0, 1'b1, 1'b0};
    tbl[7]  = '{8'h73, 19'd1736,   1'b0, 1'b0, 1'b1};
    tbl[8]  = '{8'h8C, 19'd868,    1'b1, 1'b1, 1'b0};
    tbl[9]  = '{8'h9E, 19'd868,    1'b1, 1'b1, 1'b1};
    tbl[10] = '{8'hC1, 19'd868,    1'b0, 1'b0, 1'b0};
    tbl[11] = '{8'hFA, 19'd868,    1'b1, 1'b0, 1'b1};

    rst = 1'b1; rx_rdy = 1'b0; rx_data = 8'h00;
    rx_ferr = 1'b0; rx_perr = 1'b0; rx_ovf = 1'b0;
    cfg_we = 1'b0; cfg_wdata = 8'h00; rd = 1'b0;
    m_ovr = 1'b0; m_k = 19'd10417; m_eight = 1'b1; m_pen = 1'b0; m_even = 1'b0;

    // Reset state
    tick(3);
    check_cfg("reset");
    check_model("reset");
    chk("reset rx_clr", 32'(rx_clr), 32'd0);
    rst = 1'b0;
    tick(2);
    check_cfg("idle");
    check_model("idle");
    chk("idle rx_clr", 32'(rx_clr), 32'd0);

    // Config 8'h8C
    cfg_write(8'h8C, exp_k(4'h8), 1'b1, 1'b1, 1'b0);

    // Single frame with parity error; RXRDY held to exercise WAIT
    send_byte(8'hA5, 3'b001, 2, lat);
    chk("rx_clr latency", 32'(lat), 32'd3);
    check_model("A5");
    chk("A5 rd_data", 32'(rd_data), 32'hA5);
    chk("A5 rd_status", 32'(rd_status), 32'h1);
    pop_one("A5 pop");

    // Overflow: 9 frames into 8 entries
    c0 = clr_cnt;
    for (int i = 0; i < 9; i++) send_byte(8'(i), 3'b000, 0, lat);
    chk("ovf clr count", 32'(clr_cnt - c0), 32'd9);
    check_model("ovf filled");
    chk("ovf full", 32'(full), 32'd1);
    chk("ovf ovr", 32'(ovr), 32'd1);
    for (int i = 0; i < 8; i++) pop_one("ovf drain");
    chk("ovf drained empty", 32'(empty), 32'd1);
    chk("ovf sticky", 32'(ovr), 32'd1);
    pop_one("pop empty");
    cfg_write(8'h8C, exp_k(4'h8), 1'b1, 1'b1, 1'b0);
    chk("ovr cleared by cfg", 32'(ovr), 32'd0);

    // Simultaneous push/pop on non-full then full FIFO
    send_byte(8'h10, 3'b010, 0, lat);
    send_byte(8'h11, 3'b100, 0, lat);
    push_pop("pp nonfull", 8'h12, 3'b011);
    for (int i = 0; i < 6; i++) send_byte(8'h20 + 8'(i), 3'b000, 0, lat);
    chk("pp full before", 32'(full), 32'd1);
    push_pop("pp full", 8'h55, 3'b110);
    chk("pp full ovr", 32'(ovr), 32'd0);
    chk("pp full count", 32'(count), 32'd8);

    // Config table; some entries with data queued to show the flush
    for (int i = 0; i < 12; i++) begin
      if (i % 3 == 0) send_byte(8'(8'hC0 + i), 3'b101, 0, lat);
      cfg_write(tbl[i].wdata, tbl[i].k, tbl[i].eight, tbl[i].pen, tbl[i].even);
      chk("tbl k vs baud rule", 32'(k), 32'(exp_k(tbl[i].wdata[7:4])));
    end

    // Idle timeout
    cfg_write(8'h8C, exp_k(4'h8), 1'b1, 1'b1, 1'b0);
    send_byte(8'h77, 3'b000, 0, lat);
`ifdef RX_TIMEOUT_EN
    tick(27000);
    chk("timeout early", 32'(timeout), 32'd0);
    tick(1000);
    chk("timeout set", 32'(timeout), 32'd1);
    chk("timeout irq", 32'(irq), 32'd1);
    rd = 1'b1;
    tick(1);
    rd = 1'b0;
    void'(mq.pop_front());
    check_model("timeout pop");
`else
    tick(3000);
    chk("timeout disabled", 32'(timeout), 32'd0);
    chk("timeout disabled irq", 32'(irq), 32'd1);
    pop_one("timeout pop");
`endif

    // Randomized traffic
    for (int i = 0; i < 250; i++) begin
      int op;
      op = int'($urandom_range(0, 9));
      if (op < 5) begin
        send_byte(8'($urandom), 3'($urandom_range(0, 7)), int'($urandom_range(0, 2)), lat);
        check_model("rnd push");
      end else if (op < 8) begin
        pop_one("rnd pop");
      end else if (op < 9) begin
        push_pop("rnd pp", 8'($urandom), 3'($urandom_range(0, 7)));
      end else begin
        rb = 8'($urandom);
        cfg_write(rb, exp_k(rb[7:4]), rb[3], rb[2], rb[1]);
      end
    end

    // Reset mid-frame: the captured byte is lost
    send_byte(8'h5A, 3'b000, 0, lat);
    rx_data = 8'h3C;
    rx_rdy = 1'b1;
    tick(1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    rx_rdy = 1'b0;
    mq.delete();
    m_ovr = 1'b0; m_k = 19'd10417; m_eight = 1'b1; m_pen = 1'b0; m_even = 1'b0;
    check_model("rst mid");
    check_cfg("rst mid");
    chk("rst mid rx_clr", 32'(rx_clr), 32'd0);
    tick(3);
    chk("rst mid no clr", 32'(rx_clr), 32'd0);
    check_model("rst mid after");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
